// File: rtl/vga_pkg.sv
// Shared colour constants, pattern mode encodings and default VGA
// geometry for the pattern source and its box animator.
package vga_pkg;

  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] BLACK   = 16'h0000;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'd0,
    MODE_GRID     = 3'd1,
    MODE_BARS     = 3'd2,
    MODE_CHECK    = 3'd3,
    MODE_BOX      = 3'd4,
    MODE_GRADIENT = 3'd5
  } mode_e;

  function automatic logic [15:0] bar_color(
    input logic [2:0] idx
  );
    logic [15:0] c;
    c = BLACK;
    case (idx)
      3'd0: c = WHITE;
      3'd1: c = YELLOW;
      3'd2: c = CYAN;
      3'd3: c = GREEN;
      3'd4: c = MAGENTA;
      3'd5: c = RED;
      3'd6: c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_box_anim.sv
// Bouncing-box position: moves BOX_STEP per axis on every step_i
// and reflects off the edges of the visible area.
module vga_box_anim
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2,
  parameter int H_W      = 10,
  parameter int V_W      = 10
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  input  logic           step_i,
  output logic [H_W-1:0] bx_o,
  output logic [V_W-1:0] by_o
);

  localparam int XMAX = H_ACTIVE - BOX_SIZE;
  localparam int YMAX = V_ACTIVE - BOX_SIZE;

  logic           dx_neg;
  logic           dy_neg;
  logic [H_W:0]   bx_fwd;
  logic [V_W:0]   by_fwd;

  // one extra bit so the forward sum cannot wrap
  assign bx_fwd = {1'b0, bx_o} + (H_W+1)'(BOX_STEP);
  assign by_fwd = {1'b0, by_o} + (V_W+1)'(BOX_STEP);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bx_o   <= '0;
      dx_neg <= 1'b0;
    end else if (step_i) begin
      if (!dx_neg) begin
        if (bx_fwd >= (H_W+1)'(XMAX)) begin
          bx_o   <= H_W'(XMAX);
          dx_neg <= 1'b1;
        end else begin
          bx_o <= bx_fwd[H_W-1:0];
        end
      end else begin
        if ({1'b0, bx_o} <= (H_W+1)'(BOX_STEP)) begin
          bx_o   <= '0;
          dx_neg <= 1'b0;
        end else begin
          bx_o <= bx_o - H_W'(BOX_STEP);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      by_o   <= '0;
      dy_neg <= 1'b0;
    end else if (step_i) begin
      if (!dy_neg) begin
        if (by_fwd >= (V_W+1)'(YMAX)) begin
          by_o   <= V_W'(YMAX);
          dy_neg <= 1'b1;
        end else begin
          by_o <= by_fwd[V_W-1:0];
        end
      end else begin
        if ({1'b0, by_o} <= (V_W+1)'(BOX_STEP)) begin
          by_o   <= '0;
          dy_neg <= 1'b0;
        end else begin
          by_o <= by_o - V_W'(BOX_STEP);
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern source, registered RGB565 output.
// Optional white frame border with `define PATTERN_BORDER_EN.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE    = H_ACTIVE_DEF,
  parameter int          V_ACTIVE    = V_ACTIVE_DEF,
  parameter int          H_W         = 10,
  parameter int          V_W         = 10,
  parameter int          GRID_LOG2   = 3,
  parameter int          CHECK_LOG2  = 5,
  parameter int          BOX_SIZE    = 32,
  parameter int          BOX_STEP    = 2,
  parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  input  logic           enable_i,
  input  logic [2:0]     mode_i,
  input  logic           active_i,
  input  logic [H_W-1:0] hpos_i,
  input  logic [V_W-1:0] vpos_i,
  output logic [15:0]    rgb_o,
  output logic [2:0]     mode_o,
  output logic [15:0]    frame_cnt_o
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic           taken;
  logic           frame_start;
  logic [H_W-1:0] bx;
  logic [V_W-1:0] by;
  logic           in_box;
  logic [2:0]     bar;
  logic [15:0]    pat;
  logic [15:0]    pix;

  // taken blocks repeat pulses while (0,0) is held; any nonzero line clears it
  assign frame_start = active_i && (hpos_i == '0)
                    && (vpos_i == '0) && !taken;

  vga_box_anim #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP),
    .H_W      (H_W),
    .V_W      (V_W)
  ) u_box (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .step_i   (frame_start),
    .bx_o     (bx),
    .by_o     (by)
  );

  assign in_box =
       ({1'b0, hpos_i} >= {1'b0, bx})
    && ({1'b0, hpos_i} <  {1'b0, bx} + (H_W+1)'(BOX_SIZE))
    && ({1'b0, vpos_i} >= {1'b0, by})
    && ({1'b0, vpos_i} <  {1'b0, by} + (V_W+1)'(BOX_SIZE));

  assign bar = 3'(hpos_i / H_W'(BAR_W));

  always_comb begin
    pat = BLACK;
    case (mode_o)
      MODE_SOLID: pat = SOLID_COLOR;
      MODE_GRID: begin
        if (hpos_i[GRID_LOG2-1:0] == '0 ||
            vpos_i[GRID_LOG2-1:0] == '0)
          pat = RED;
        else if (vpos_i[4])
          pat = GREEN;
        else if (hpos_i[4])
          pat = BLUE;
        else
          pat = BLACK;
      end
      MODE_BARS: pat = bar_color(bar);
      MODE_CHECK: begin
        pat = (hpos_i[CHECK_LOG2] ^ vpos_i[CHECK_LOG2]
               ^ frame_cnt_o[5]) ? WHITE : BLACK;
      end
      MODE_BOX: pat = in_box ? WHITE : BLUE;
      MODE_GRADIENT: begin
        pat = {hpos_i[H_W-1 -: 5],
               vpos_i[V_W-1 -: 6],
               frame_cnt_o[4:0]};
      end
      default: pat = BLACK;
    endcase
  end

`ifdef PATTERN_BORDER_EN
  logic on_border;
  assign on_border = (hpos_i == '0)
                  || (hpos_i == H_W'(H_ACTIVE-1))
                  || (vpos_i == '0)
                  || (vpos_i == V_W'(V_ACTIVE-1));
  assign pix = on_border ? WHITE : pat;
`else
  assign pix = pat;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      taken       <= 1'b0;
      mode_o      <= '0;
      frame_cnt_o <= '0;
      rgb_o       <= '0;
    end else begin
      rgb_o <= (active_i && enable_i) ? pix : BLACK;
      if (frame_start) begin
        taken       <= 1'b1;
        mode_o      <= mode_i;
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end else if (vpos_i != '0) begin
        taken <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: vector table plus frame,
// bounce, checkerboard and reset sequences.
module tb_vga_pattern_gen;

`ifdef PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  mode_in;
  logic        act;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic [15:0] rgb;
  logic [2:0]  mode_out;
  logic [15:0] fcnt;

  int n_run  = 0;
  int n_fail = 0;
  int fc, bx, by, dx, dy;

  always #5 clk = ~clk;

  vga_pattern_gen dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .enable_i    (enable),
    .mode_i      (mode_in),
    .active_i    (act),
    .hpos_i      (hpos),
    .vpos_i      (vpos),
    .rgb_o       (rgb),
    .mode_o      (mode_out),
    .frame_cnt_o (fcnt)
  );

  typedef struct {
    logic [2:0]  mode;
    logic        en;
    logic        act;
    int          h;
    int          v;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name,
                       input logic [15:0] got,
                       input logic [15:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic pix(input logic a, input logic e,
                     input int h, input int v);
    act    = a;
    enable = e;
    hpos   = 10'(h);
    vpos   = 10'(v);
    @(negedge clk);
  endtask

  task automatic box_reset();
    bx = 0; by = 0; dx = 1; dy = 1;
  endtask

  task automatic box_step();
    if (dx > 0) begin
      if (bx + 2 >= 608) begin bx = 608; dx = -1; end
      else bx = bx + 2;
    end else begin
      if (bx <= 2) begin bx = 0; dx = 1; end
      else bx = bx - 2;
    end
    if (dy > 0) begin
      if (by + 2 >= 448) begin by = 448; dy = -1; end
      else by = by + 2;
    end else begin
      if (by <= 2) begin by = 0; dy = 1; end
      else by = by - 2;
    end
  endtask

  task automatic frame();
    pix(1'b1, 1'b1, 0, 0);
    fc = (fc + 1) & 16'hFFFF;
    box_step();
    pix(1'b1, 1'b1, 5, 1);
  endtask

  function automatic logic [15:0] chk_exp(input int h, input int v);
    int b;
    b = ((h >> 5) ^ (v >> 5) ^ (fc >> 5)) & 1;
    return (b != 0) ? 16'hFFFF : 16'h0000;
  endfunction

  task automatic box_checks(input string tag);
    check({tag, "_cnt"}, fcnt, 16'(fc));
    pix(1'b1, 1'b1, bx, by);
    check({tag, "_tl"}, rgb, 16'hFFFF);
    pix(1'b1, 1'b1, bx + 31, by + 31);
    check({tag, "_br"}, rgb, 16'hFFFF);
    pix(1'b1, 1'b1, bx - 1, by);
    check({tag, "_left"}, rgb, 16'h001F);
    pix(1'b1, 1'b1, bx, by + 32);
    check({tag, "_below"}, rgb, 16'h001F);
    if (bx + 32 < 639) begin
      pix(1'b1, 1'b1, bx + 32, by);
      check({tag, "_right"}, rgb, 16'h001F);
    end
  endtask

  initial begin
    logic [2:0] cur;
    int f5;

    vecs[0]  = '{3'd1, 1'b1, 1'b1, 9,   9,  16'h0000};
    vecs[1]  = '{3'd1, 1'b1, 1'b1, 8,   5,  16'hF800};
    vecs[2]  = '{3'd1, 1'b1, 1'b1, 9,   17, 16'h07E0};
    vecs[3]  = '{3'd1, 1'b1, 1'b1, 17,  9,  16'h001F};
    vecs[4]  = '{3'd1, 1'b1, 1'b1, 3,   16, 16'hF800};
    vecs[5]  = '{3'd2, 1'b1, 1'b1, 1,   1,  16'hFFFF};
    vecs[6]  = '{3'd2, 1'b1, 1'b1, 79,  1,  16'hFFFF};
    vecs[7]  = '{3'd2, 1'b1, 1'b1, 80,  1,  16'hFFE0};
    vecs[8]  = '{3'd2, 1'b1, 1'b1, 159, 1,  16'hFFE0};
    vecs[9]  = '{3'd2, 1'b1, 1'b1, 160, 1,  16'h07FF};
    vecs[10] = '{3'd2, 1'b1, 1'b1, 240, 1,  16'h07E0};
    vecs[11] = '{3'd2, 1'b1, 1'b1, 320, 1,  16'hF81F};
    vecs[12] = '{3'd2, 1'b1, 1'b1, 400, 1,  16'hF800};
    vecs[13] = '{3'd2, 1'b1, 1'b1, 480, 1,  16'h001F};
    vecs[14] = '{3'd2, 1'b1, 1'b1, 638, 1,  16'h0000};
    vecs[15] = '{3'd2, 1'b1, 1'b0, 100, 1,  16'h0000};
    vecs[16] = '{3'd2, 1'b0, 1'b1, 100, 1,  16'h0000};
    vecs[17] = '{3'd0, 1'b1, 1'b1, 5,   5,  16'hF800};
    vecs[18] = '{3'd6, 1'b1, 1'b1, 5,   5,  16'h0000};
    vecs[19] = '{3'd7, 1'b1, 1'b1, 9,   9,  16'h0000};

    rst_n = 1'b0; enable = 1'b0; mode_in = 3'd0;
    act = 1'b0; hpos = '0; vpos = '0;
    fc = 0; box_reset();
    @(negedge clk); @(negedge clk);
    check("rst_rgb",  rgb, 16'h0000);
    check("rst_mode", 16'(mode_out), 16'h0000);
    check("rst_cnt",  fcnt, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // first frame: new mode registered, old mode paints (0,0)
    mode_in = 3'd1;
    pix(1'b1, 1'b1, 0, 0);
    fc = 1; box_step();
    check("first_mode", 16'(mode_out), 16'h0001);
    check("first_cnt",  fcnt, 16'h0001);
    check("first_pix",  rgb, BORDER ? 16'hFFFF : 16'hF800);
    cur = 3'd1;

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].mode != cur) begin
        mode_in = vecs[i].mode;
        frame();
        cur = vecs[i].mode;
        check($sformatf("vec%0d_mode", i), 16'(mode_out), 16'(cur));
      end
      pix(vecs[i].act, vecs[i].en, vecs[i].h, vecs[i].v);
      check($sformatf("vec%0d", i), rgb, vecs[i].exp);
    end

    // mid-frame request is held off until the next frame start
    mode_in = 3'd2;
    frame();
    mode_in = 3'd0;
    pix(1'b1, 1'b1, 100, 5);
    check("mid_keep", rgb, 16'hFFE0);
    check("mid_mode_keep", 16'(mode_out), 16'h0002);
    pix(1'b1, 1'b1, 0, 0);
    fc = (fc + 1) & 16'hFFFF; box_step();
    check("mid_first_px", rgb, 16'hFFFF);
    check("mid_mode_new", 16'(mode_out), 16'h0000);
    pix(1'b1, 1'b1, 100, 5);
    check("mid_solid", rgb, 16'hF800);

    // enable low blanks output but frames still count
    pix(1'b1, 1'b0, 0, 0);
    fc = (fc + 1) & 16'hFFFF; box_step();
    pix(1'b1, 1'b0, 5, 1);
    check("en0_rgb", rgb, 16'h0000);
    check("en0_cnt", fcnt, 16'(fc));

    // checkerboard polarity follows frame_cnt bit 5
    mode_in = 3'd3;
    frame();
    pix(1'b1, 1'b1, 32, 1);
    check("chk_a", rgb, chk_exp(32, 1));
    pix(1'b1, 1'b1, 32, 32);
    check("chk_b", rgb, chk_exp(32, 32));
    f5 = (fc >> 5) & 1;
    for (int k = 0; k < 64 && ((fc >> 5) & 1) == f5; k++)
      frame();
    pix(1'b1, 1'b1, 32, 1);
    check("chk_flip_a", rgb, chk_exp(32, 1));
    pix(1'b1, 1'b1, 32, 32);
    check("chk_flip_b", rgb, chk_exp(32, 32));

    // gradient
    mode_in = 3'd5;
    frame();
    pix(1'b1, 1'b1, 320, 240);
    check("grad_a", rgb, {5'd10, 6'd15, 5'(fc)});
    pix(1'b1, 1'b1, 100, 400);
    check("grad_b", rgb, {5'd3, 6'd25, 5'(fc)});

    // right edge in checkerboard mode
    mode_in = 3'd3;
    frame();
    pix(1'b1, 1'b1, 639, 200);
    check("edge_639", rgb, BORDER ? 16'hFFFF : chk_exp(639, 200));

    // asynchronous reset in the middle of a line
    pix(1'b1, 1'b1, 64, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rgb",  rgb, 16'h0000);
    check("arst_mode", 16'(mode_out), 16'h0000);
    check("arst_cnt",  fcnt, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    fc = 0; box_reset();
    mode_in = 3'd4;
    pix(1'b1, 1'b1, 0, 0);
    fc = 1; box_step();
    check("arst_restart", fcnt, 16'h0001);
    pix(1'b1, 1'b1, 5, 1);

    // bounce: right wall hit at frame 304, reversal at 305
    for (int k = 0; k < 1000 && fc < 304; k++)
      frame();
    box_checks("box304");
    frame();
    box_checks("box305");
    for (int k = 0; k < 1000 && fc < 400; k++)
      frame();
    box_checks("box400");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised, multi-mode test-pattern source for the VGA path. It sits upstream of vgaDriver, consumes the driver's pixel coordinates, and returns a registered RGB565 pixel. It replaces the fixed grid-pattern top-level generator with:
- selectable patterns, changed only on frame boundaries;
- a frame counter;
- an animated bouncing box.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
H_W, 10, width of horizontal coordinate
V_W, 10, width of vertical coordinate
GRID_LOG2, 3, grid pitch = 2**GRID_LOG2 pixels
CHECK_LOG2, 5, checkerboard cell = 2**CHECK_LOG2 pixels
BOX_SIZE, 32, bouncing-box edge length in pixels
BOX_STEP, 2, box displacement per frame per axis
SOLID_COLOR, 16'hF800, mode-0 fill colour

Ports:
clk_i  in  1  pixel clock, shared with vgaDriver
reset_ni  in  1  asynchronous, active-low reset
enable_i  in  1  1 = generate pattern; 0 = force black output
mode_i  in  3  requested pattern, sampled at frame start
active_i  in  1  driver is in the visible region
hpos_i  in  H_W  current column
vpos_i  in  V_W  current line
rgb_o  out  16  RGB565 pixel, one cycle after its coordinates
mode_o  out  3  pattern currently in effect
frame_cnt_o  out  16  frames generated since reset, wraps

Behaviour:
- Reset is asynchronous on negedge reset_ni. Reset values:
  - rgb_o=0, mode_o=0, frame_cnt_o=0;
  - box at (0,0), both box directions +.
- frame_start = active_i && hpos_i==0 && vpos_i==0.
  - An internal armed flag ensures one pulse per frame.
  - The flag re-arms when vpos_i != 0.
- On frame_start, all of the following take effect in the same cycle:
  - mode_o <= mode_i;
  - frame_cnt_o <= frame_cnt_o+1, wrapping 16'hFFFF -> 0;
  - box advances.
- Mid-frame changes on mode_i are ignored until the next frame_start.
- The first pixel of a frame uses the old mode. rgb_o is computed from the registered mode_o, so the new mode applies from the next pixel.
- Latency: rgb_o is registered and valid exactly 1 clk after hpos_i/vpos_i/active_i.
- active_i=0 or enable_i=0 -> rgb_o=0 on the next cycle. enable_i does not stop frame_cnt_o or the box.
- Modes (mode_o):
  - 0 solid: SOLID_COLOR.
  - 1 grid: red F800 if hpos or vpos low GRID_LOG2 bits are all 0; else green 07E0 if vpos[4]; else blue 001F if hpos[4]; else black. No latched state.
  - 2 colour bars: 8 equal bars of H_ACTIVE/8 pixels, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 3 checkerboard: white if hpos[CHECK_LOG2]^vpos[CHECK_LOG2]^frame_cnt_o[5], else black. The pattern inverts every 32 frames.
  - 4 bouncing box: FFFF inside [bx,bx+BOX_SIZE) x [by,by+BOX_SIZE), else 001F.
  - 5 gradient: R = hpos[H_W-1 -: 5], G = vpos[V_W-1 -: 6], B = frame_cnt_o[4:0].
  - 6, 7: black 0000. mode_o still reports 6/7.
- Box update, per axis, on frame_start (X axis shown):
  - dir +: if bx+BOX_STEP >= H_ACTIVE-BOX_SIZE then bx <= H_ACTIVE-BOX_SIZE and dir <= -; else bx <= bx+BOX_STEP.
  - dir -: if bx <= BOX_STEP then bx <= 0 and dir <= +; else bx <= bx-BOX_STEP.
  - Y axis: identical, using V_ACTIVE.
  - Compare at H_W+1 bits to avoid overflow.
- Coordinates outside the active region are don't-care; output is still forced to 0 by active_i.
- Reset mid-frame: outputs clear immediately. The armed flag clears, so the next frame_start is taken on the next (0,0).

Optional Feature:
PATTERN_BORDER_EN
- Defined: after pattern selection, and only while active_i && enable_i, pixels with hpos==0, hpos==H_ACTIVE-1, vpos==0 or vpos==V_ACTIVE-1 are forced to FFFF. This holds in every mode.
- Undefined: no border logic; pattern colours are unmodified.

Decomposition:
- Shared package vga_pkg:
  - RGB565 colour constants (RED F800, GREEN 07E0, BLUE 001F, YELLOW FFE0, MAGENTA F81F, CYAN 07FF, WHITE, BLACK);
  - mode encodings MODE_SOLID..MODE_GRADIENT;
  - default H_ACTIVE/V_ACTIVE.
- Sub-module vga_box_anim: per-frame bounce of bx/by with direction registers. Parameters H_ACTIVE, V_ACTIVE, BOX_SIZE, BOX_STEP; inputs step_i=frame_start, clk_i, reset_ni.

Test Plan:
- Reset, then mode_i=1, active_i=1, (hpos,vpos)=(0,0) -> next clk mode_o=1, frame_cnt_o=1; then (hpos,vpos)=(9,9) -> rgb_o=0000 one cycle later; (8,5) -> F800; (9,17) -> 07E0.
- mode_i=2, sweep one line -> rgb_o changes at hpos 80,160,...,560 through the 8 listed colours; active_i=0 -> 0000.
- Mid-frame change mode_i 2->0 -> rgb_o keeps bars until the next (0,0); from the following pixel, rgb_o = F800.
- Mode 4 at 640x480, BOX_SIZE 32, STEP 2, over 400 frames -> bx reaches 608 at frame 304, direction flips, bx=606 at frame 305; box is white at (bx,by), blue at (bx+32,by).
- Force frame_cnt_o to FFFF via 65535 frame starts (or a shortened param) -> next frame gives 0000; checkerboard polarity flips when frame_cnt_o[5] toggles.
- Assert reset_ni low mid-line -> rgb_o, mode_o and frame_cnt_o are 0 before the next clk edge. With PATTERN_BORDER_EN, (639,200) in mode 3 -> FFFF.
